// File: rtl/cordic_pkg.sv
// Shared constants and types for the cosine CORDIC back end.
package cordic_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FIXED_FRAC = 31;
  localparam int FP_MANT_W  = 23;
  localparam int FP_EXP_W   = 8;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  expo;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

  localparam fp32_t FP_ZERO = '0;

endpackage

// File: rtl/cordic_result_fifo_lzc32.sv
// lzc32: combinational leading-one position encoder for a 32-bit word.
// Built as a two-level tree of 4-bit priority encoders.
module lzc32 (
  input  logic [31:0] data,
  output logic [4:0]  pos,
  output logic        zero
);

  // {any-bit-set, position of highest set bit}
  function automatic logic [2:0] enc4(input logic [3:0] v);
    casez (v)
      4'b1???: enc4 = 3'b111;
      4'b01??: enc4 = 3'b110;
      4'b001?: enc4 = 3'b101;
      4'b0001: enc4 = 3'b100;
      default: enc4 = 3'b000;
    endcase
  endfunction

  logic [7:0]      nib_v;
  logic [7:0][1:0] nib_p;
  logic [1:0]      grp_v;
  logic [1:0][1:0] grp_p;
  logic [2:0]      nib_sel;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_nib
      assign {nib_v[i], nib_p[i]} = enc4(data[4*i +: 4]);
    end
    for (genvar g = 0; g < 2; g++) begin : g_grp
      assign {grp_v[g], grp_p[g]} = enc4(nib_v[4*g +: 4]);
    end
  endgenerate

  // Upper group wins whenever it holds any set bit.
  assign nib_sel = {grp_v[1], grp_p[grp_v[1]]};
  assign pos     = {nib_sel, nib_p[nib_sel]};
  assign zero    = ~(grp_v[1] | grp_v[0]);

endmodule

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo: signed Q0.31 -> IEEE-754 single, two-stage convert,
// credit-throttled FWFT result FIFO.
// Build option: CORDIC_FTOF_ROUND_EN selects round-to-nearest-even instead
// of truncation in the pack stage. FIXED_W is expected to be 32.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int FIXED_W = 32
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   clk_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FIXED_W-1:0]     in_fixed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_float,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              OW      = PW + 1;
  localparam logic [OW-1:0]   DEPTH_C = OW'(DEPTH);
  localparam logic [7:0]      EXP_OFS = 8'(FP_BIAS - FIXED_FRAC);

  logic          accept, wr_en, pop;
  logic [31:0]   mag_c;
  logic [4:0]    pos_c;
  logic          zero_c;

  logic          s1_vld_q, s1_sign_q, s1_zero_q;
  logic [31:0]   s1_mag_q;
  logic [4:0]    s1_pos_q;

  logic [7:0]    expo_c;
  logic [22:0]   mant_c;
  fp32_t         pk_d;
`ifdef CORDIC_FTOF_ROUND_EN
  logic [30:0]   norm_c;
  logic          rnd_c, carry_c;
`endif

  fp32_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] cnt_q, cnt_d, occ_q, occ_d;

  // Credit comes from registered occupancy only; out_ready never feeds it.
  assign in_ready  = occ_q < DEPTH_C;
  assign accept    = in_valid & in_ready & clk_en;
  assign wr_en     = s1_vld_q & clk_en;
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid & out_ready;
  assign out_float = out_valid ? mem_q[rd_ptr_q] : FP_ZERO;
  assign occupancy = occ_q;

  // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
  assign mag_c = in_fixed[FIXED_W-1] ? (~in_fixed + 32'd1) : in_fixed;

  lzc32 u_lzc (
    .data (mag_c),
    .pos  (pos_c),
    .zero (zero_c)
  );

  // S1: capture sign, magnitude and leading-one position; frozen when clk_en low.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_pos_q  <= '0;
    end else if (clk_en) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_sign_q <= in_fixed[FIXED_W-1];
        s1_zero_q <= zero_c;
        s1_mag_q  <= mag_c;
        s1_pos_q  <= pos_c;
      end
    end
  end

  // S2: normalise so the leading one drops off, then pack the float.
  always_comb begin
`ifdef CORDIC_FTOF_ROUND_EN
    norm_c           = 31'(s1_mag_q << (5'd31 - s1_pos_q));
    rnd_c            = norm_c[7] & ((|norm_c[6:0]) | norm_c[8]);
    {carry_c, mant_c} = {1'b0, norm_c[30:8]} + 24'(rnd_c);
    expo_c           = EXP_OFS + {3'b000, s1_pos_q} + 8'(carry_c);
`else
    mant_c = 23'((s1_mag_q << (5'd31 - s1_pos_q)) >> 8);
    expo_c = EXP_OFS + {3'b000, s1_pos_q};
`endif
    pk_d = s1_zero_q ? FP_ZERO : {s1_sign_q, expo_c, mant_c};
  end

  // FIFO storage and pointers; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= FP_ZERO;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= pk_d;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO fill count and credit count (FIFO entries plus the S1 token).
  always_comb begin
    cnt_d = cnt_q;
    occ_d = occ_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: ;
    endcase
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: ;
    endcase
  end

  // Counter registers.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      cnt_q <= '0;
      occ_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end
  end

endmodule
